// File: rtl/gambit_bu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | gambit_bu_pkg : branch opcodes, status bit positions, lane type |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package gambit_bu_pkg;

   localparam int OPW = 6;

   localparam logic [OPW-1:0] UO_BEQ = 6'd0;
   localparam logic [OPW-1:0] UO_BNE = 6'd1;
   localparam logic [OPW-1:0] UO_BCS = 6'd2;
   localparam logic [OPW-1:0] UO_BCC = 6'd3;
   localparam logic [OPW-1:0] UO_BVS = 6'd4;
   localparam logic [OPW-1:0] UO_BVC = 6'd5;
   localparam logic [OPW-1:0] UO_BMI = 6'd6;
   localparam logic [OPW-1:0] UO_BPL = 6'd7;
   localparam logic [OPW-1:0] UO_BHI = 6'd8;
   localparam logic [OPW-1:0] UO_BLS = 6'd9;
   localparam logic [OPW-1:0] UO_BGE = 6'd10;
   localparam logic [OPW-1:0] UO_BLT = 6'd11;
   localparam logic [OPW-1:0] UO_BGT = 6'd12;
   localparam logic [OPW-1:0] UO_BLE = 6'd13;
   localparam logic [OPW-1:0] UO_BRA = 6'd14;
   localparam logic [OPW-1:0] UO_BRN = 6'd15;

   localparam int SR_C = 0;
   localparam int SR_Z = 1;
   localparam int SR_V = 6;
   localparam int SR_N = 7;

   // Lane container sized for the widest supported configuration; the
   // top zero-extends narrower addresses and tags into it.
   localparam int LANE_SRW      = 8;
   localparam int LANE_AW_MAX   = 128;
   localparam int LANE_TAGW_MAX = 32;

   typedef struct packed {
      logic [OPW-1:0]           op;
      logic [LANE_SRW-1:0]      sr;
      logic                     pred;
      logic [LANE_AW_MAX-1:0]   tgt;
      logic [LANE_AW_MAX-1:0]   fall;
      logic [LANE_TAGW_MAX-1:0] tag;
   } lane_t;

endpackage
`default_nettype wire

// File: rtl/gambit_branch_cond.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | gambit_branch_cond : opcode + status flags -> taken (comb)      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module gambit_branch_cond
   import gambit_bu_pkg::*;
(
   input  logic [OPW-1:0]      op_i,
   input  logic [LANE_SRW-1:0] sr_i,
   output logic                taken_o
);

   logic w_c;
   logic w_z;
   logic w_v;
   logic w_n;
   logic w_unused;

   assign w_c      = sr_i[SR_C];
   assign w_z      = sr_i[SR_Z];
   assign w_v      = sr_i[SR_V];
   assign w_n      = sr_i[SR_N];
   assign w_unused = ^sr_i[5:2];

   always_comb begin
      taken_o = 1'b1;
      case (op_i)
         UO_BEQ:  taken_o = w_z;
         UO_BNE:  taken_o = !w_z;
         UO_BCS:  taken_o = w_c;
         UO_BCC:  taken_o = !w_c;
         UO_BVS:  taken_o = w_v;
         UO_BVC:  taken_o = !w_v;
         UO_BMI:  taken_o = w_n;
         UO_BPL:  taken_o = !w_n;
         UO_BHI:  taken_o = w_c & !w_z;
         UO_BLS:  taken_o = !w_c | w_z;
         UO_BGE:  taken_o = (w_n == w_v);
         UO_BLT:  taken_o = (w_n != w_v);
         UO_BGT:  taken_o = !w_z & (w_n == w_v);
         UO_BLE:  taken_o = w_z | (w_n != w_v);
         UO_BRA:  taken_o = 1'b1;
         UO_BRN:  taken_o = 1'b0;
         default: taken_o = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/gambit_branch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | gambit_branch_unit : 2-stage multi-lane branch resolve/redirect |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module gambit_branch_unit
   import gambit_bu_pkg::*;
#(
   parameter int NCH  = 2,
   parameter int SRW  = 8,
   parameter int AW   = 32,
   parameter int TAGW = 5,
   parameter int CNTW = 16
)(
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic [NCH-1:0]      in_valid_i,
   output logic                in_ready_o,
   input  logic [NCH*OPW-1:0]  in_op_i,
   input  logic [NCH*SRW-1:0]  in_sr_i,
   input  logic [NCH-1:0]      in_pred_i,
   input  logic [NCH*AW-1:0]   in_tgt_i,
   input  logic [NCH*AW-1:0]   in_fall_i,
   input  logic [NCH*TAGW-1:0] in_tag_i,
   output logic [NCH-1:0]      out_valid_o,
   input  logic                out_ready_i,
   output logic [NCH-1:0]      out_taken_o,
   output logic [NCH*TAGW-1:0] out_tag_o,
   output logic                redir_o,
   output logic [AW-1:0]       redir_addr_o,
   output logic [TAGW-1:0]     redir_tag_o,
   output logic [CNTW-1:0]     mispred_cnt_o
);

   lane_t                     w_lane [NCH];
   logic [NCH-1:0]            w_taken;

   logic [NCH-1:0]            s1_valid_q;
   logic [NCH-1:0]            s1_pred_q;
   logic [NCH-1:0]            s1_taken_q;
   logic [NCH-1:0][AW-1:0]    s1_tgt_q;
   logic [NCH-1:0][AW-1:0]    s1_fall_q;
   logic [NCH-1:0][TAGW-1:0]  s1_tag_q;

   logic [NCH-1:0]            s2_valid_q;
   logic [NCH-1:0]            s2_taken_q;
   logic [NCH*TAGW-1:0]       s2_tag_q;
   logic                      s2_redir_q;
   logic [AW-1:0]             s2_addr_q;
   logic [TAGW-1:0]           s2_rtag_q;
   logic [CNTW-1:0]           cnt_q;

   logic                      w_s1_any;
   logic                      w_s2_any;
   logic                      w_out_fire;
   logic                      w_s1_adv;
   logic                      w_in_fire;
   logic [NCH-1:0]            w_kill_valid;
   logic                      w_redir;
   logic [AW-1:0]             w_raddr;
   logic [TAGW-1:0]           w_rtag;

   for (genvar i = 0; i < NCH; i++) begin : g_lane
      logic w_unused;

      assign w_lane[i] = '{
         op:   in_op_i[i*OPW +: OPW],
         sr:   in_sr_i[i*SRW +: LANE_SRW],
         pred: in_pred_i[i],
         tgt:  LANE_AW_MAX'(in_tgt_i[i*AW +: AW]),
         fall: LANE_AW_MAX'(in_fall_i[i*AW +: AW]),
         tag:  LANE_TAGW_MAX'(in_tag_i[i*TAGW +: TAGW])
      };

      assign w_unused = ^{w_lane[i].tgt[LANE_AW_MAX-1:AW],
                          w_lane[i].fall[LANE_AW_MAX-1:AW],
                          w_lane[i].tag[LANE_TAGW_MAX-1:TAGW]};

      gambit_branch_cond u_cond (
         .op_i    (w_lane[i].op),
         .sr_i    (w_lane[i].sr),
         .taken_o (w_taken[i])
      );
   end

   assign w_s1_any   = |s1_valid_q;
   assign w_s2_any   = |s2_valid_q;
   assign w_out_fire = w_s2_any & out_ready_i;
   assign w_s1_adv   = w_s1_any & (!w_s2_any | out_ready_i);
   assign in_ready_o = !w_s1_any | w_s1_adv;
   assign w_in_fire  = (|in_valid_i) & in_ready_o & !flush_i;

   // Oldest mispredicting lane wins; everything younger is wrong-path.
   always_comb begin
      w_kill_valid = s1_valid_q;
      w_redir      = 1'b0;
      w_raddr      = '0;
      w_rtag       = '0;
      for (int k = 0; k < NCH; k++) begin
         if (w_redir) begin
            w_kill_valid[k] = 1'b0;
         end else if (s1_valid_q[k] && (s1_taken_q[k] != s1_pred_q[k])) begin
            w_redir = 1'b1;
            w_raddr = s1_taken_q[k] ? s1_tgt_q[k] : s1_fall_q[k];
            w_rtag  = s1_tag_q[k];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_valid_q <= '0;
         s1_pred_q  <= '0;
         s1_taken_q <= '0;
         s1_tgt_q   <= '0;
         s1_fall_q  <= '0;
         s1_tag_q   <= '0;
      end else begin
         if (flush_i) begin
            s1_valid_q <= '0;
         end else if (w_in_fire) begin
            s1_valid_q <= in_valid_i;
         end else if (w_s1_adv) begin
            s1_valid_q <= '0;
         end
         if (w_in_fire) begin
            s1_taken_q <= w_taken;
            for (int k = 0; k < NCH; k++) begin
               s1_pred_q[k] <= w_lane[k].pred;
               s1_tgt_q[k]  <= w_lane[k].tgt[AW-1:0];
               s1_fall_q[k] <= w_lane[k].fall[AW-1:0];
               s1_tag_q[k]  <= w_lane[k].tag[TAGW-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s2_valid_q <= '0;
         s2_taken_q <= '0;
         s2_tag_q   <= '0;
         s2_redir_q <= 1'b0;
         s2_addr_q  <= '0;
         s2_rtag_q  <= '0;
         cnt_q      <= '0;
      end else begin
         if (flush_i) begin
            s2_valid_q <= '0;
         end else if (w_s1_adv) begin
            s2_valid_q <= w_kill_valid;
         end else if (w_out_fire) begin
            s2_valid_q <= '0;
         end
         if (w_s1_adv) begin
            s2_taken_q <= s1_taken_q;
            s2_tag_q   <= s1_tag_q;
            s2_redir_q <= w_redir;
            s2_addr_q  <= w_raddr;
            s2_rtag_q  <= w_rtag;
         end
         // A bundle killed by flush is not a delivered redirect.
         if (w_out_fire && s2_redir_q && !flush_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNTW'(1);
         end
      end
   end

   assign out_valid_o   = s2_valid_q;
   assign out_taken_o   = s2_taken_q;
   assign out_tag_o     = s2_tag_q;
   assign redir_o       = s2_redir_q & w_s2_any;
   assign redir_addr_o  = s2_addr_q;
   assign redir_tag_o   = s2_rtag_q;
   assign mispred_cnt_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gambit_branch_unit.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_gambit_branch_unit : random + directed bench, scoreboard     |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_gambit_branch_unit;
   import gambit_bu_pkg::*;

   localparam int NCH  = 2;
   localparam int SRW  = 8;
   localparam int AW   = 32;
   localparam int TAGW = 5;
   localparam int CNTW = 4;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                flush = 1'b0;
   logic [NCH-1:0]      in_valid = '0;
   logic                in_ready;
   logic [NCH*OPW-1:0]  in_op = '0;
   logic [NCH*SRW-1:0]  in_sr = '0;
   logic [NCH-1:0]      in_pred = '0;
   logic [NCH*AW-1:0]   in_tgt = '0;
   logic [NCH*AW-1:0]   in_fall = '0;
   logic [NCH*TAGW-1:0] in_tag = '0;
   logic [NCH-1:0]      out_valid;
   logic                out_ready = 1'b1;
   logic [NCH-1:0]      out_taken;
   logic [NCH*TAGW-1:0] out_tag;
   logic                redir;
   logic [AW-1:0]       redir_addr;
   logic [TAGW-1:0]     redir_tag;
   logic [CNTW-1:0]     mispred_cnt;

   gambit_branch_unit #(
      .NCH(NCH), .SRW(SRW), .AW(AW), .TAGW(TAGW), .CNTW(CNTW)
   ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .flush_i       (flush),
      .in_valid_i    (in_valid),
      .in_ready_o    (in_ready),
      .in_op_i       (in_op),
      .in_sr_i       (in_sr),
      .in_pred_i     (in_pred),
      .in_tgt_i      (in_tgt),
      .in_fall_i     (in_fall),
      .in_tag_i      (in_tag),
      .out_valid_o   (out_valid),
      .out_ready_i   (out_ready),
      .out_taken_o   (out_taken),
      .out_tag_o     (out_tag),
      .redir_o       (redir),
      .redir_addr_o  (redir_addr),
      .redir_tag_o   (redir_tag),
      .mispred_cnt_o (mispred_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NCH-1:0]      vld;
      logic [NCH-1:0]      tkn;
      logic [NCH*TAGW-1:0] tags;
      logic                redir;
      logic [AW-1:0]       addr;
      logic [TAGW-1:0]     rtag;
      int                  stamp;
   } exp_t;

   exp_t            q[$];
   logic [CNTW-1:0] m_cnt = '0;
   int              edges = 0;
   int              n_checks = 0;
   int              n_pass = 0;
   bit              acc = 1'b0;

   always @(posedge clk) edges++;

   task automatic check_val(input string tag, input logic [63:0] obs,
                            input logic [63:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   // Flag semantics: Z zero, C carry/no-borrow, N sign, V overflow.
   function automatic bit cond_model(input logic [OPW-1:0] op, input logic [7:0] sr);
      bit c, z, v, n;
      c = sr[0]; z = sr[1]; v = sr[6]; n = sr[7];
      case (op)
         UO_BEQ: return z;
         UO_BNE: return !z;
         UO_BCS: return c;
         UO_BCC: return !c;
         UO_BVS: return v;
         UO_BVC: return !v;
         UO_BMI: return n;
         UO_BPL: return !n;
         UO_BHI: return c && !z;
         UO_BLS: return !c || z;
         UO_BGE: return n == v;
         UO_BLT: return n != v;
         UO_BGT: return !z && (n == v);
         UO_BLE: return z || (n != v);
         UO_BRA: return 1'b1;
         UO_BRN: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   function automatic exp_t model_bundle();
      exp_t e;
      bit   found, t;
      e = '0;
      found = 1'b0;
      for (int l = 0; l < NCH; l++) begin
         t = cond_model(in_op[l*OPW +: OPW], in_sr[l*SRW +: 8]);
         e.tkn[l] = t;
         e.tags[l*TAGW +: TAGW] = in_tag[l*TAGW +: TAGW];
         if (!found && in_valid[l]) begin
            e.vld[l] = 1'b1;
            if (t != in_pred[l]) begin
               found   = 1'b1;
               e.redir = 1'b1;
               e.addr  = t ? in_tgt[l*AW +: AW] : in_fall[l*AW +: AW];
               e.rtag  = in_tag[l*TAGW +: TAGW];
            end
         end
      end
      return e;
   endfunction

   task automatic evaluate();
      exp_t                e;
      bit                  vis;
      logic [NCH*TAGW-1:0] tmask;
      check_val("mispred_cnt", mispred_cnt, m_cnt);
      check_val("in_ready", in_ready, (q.size() < 2) || out_ready);
      vis = (q.size() > 0) && (edges - q[0].stamp >= 2);
      check_val("out_present", |out_valid, vis);
      acc = 1'b0;
      if (vis && out_ready && !flush && (|out_valid)) begin
         e = q.pop_front();
         tmask = '0;
         for (int l = 0; l < NCH; l++)
            if (e.vld[l]) tmask[l*TAGW +: TAGW] = '1;
         check_val("out_valid", out_valid, e.vld);
         check_val("out_taken", out_taken & e.vld, e.tkn & e.vld);
         check_val("out_tag", out_tag & tmask, e.tags & tmask);
         check_val("redir", redir, e.redir);
         if (e.redir) begin
            check_val("redir_addr", redir_addr, e.addr);
            check_val("redir_tag", redir_tag, e.rtag);
            if (m_cnt != '1) m_cnt++;
         end
      end
      if (flush) begin
         q.delete();
      end else if ((|in_valid) && in_ready) begin
         e = model_bundle();
         e.stamp = edges;
         q.push_back(e);
         acc = 1'b1;
      end
   endtask

   // Called at a falling edge with inputs already set for this cycle.
   task automatic step();
      #1;
      evaluate();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_lane(input int l, input bit v, input logic [OPW-1:0] op,
                           input logic [7:0] sr, input bit p, input logic [AW-1:0] tg,
                           input logic [AW-1:0] fa, input logic [TAGW-1:0] tg_id);
      in_valid[l]              = v;
      in_op[l*OPW +: OPW]      = op;
      in_sr[l*SRW +: SRW]      = sr;
      in_pred[l]               = p;
      in_tgt[l*AW +: AW]       = tg;
      in_fall[l*AW +: AW]      = fa;
      in_tag[l*TAGW +: TAGW]   = tg_id;
   endtask

   task automatic rand_bundle();
      logic [31:0]    r0, r1, r2, r3;
      logic [OPW-1:0] op;
      for (int l = 0; l < NCH; l++) begin
         r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
         op = ($urandom_range(0, 9) == 0) ? 6'd63 : OPW'($urandom_range(0, 15));
         set_lane(l, $urandom_range(0, 3) != 0, op, r0[7:0], r0[8], r1, r2, r3[4:0]);
      end
   endtask

   task automatic send(input int max_cyc);
      int c;
      c = 0;
      do begin
         step();
         c++;
      end while (!acc && c < max_cyc);
      check_val("accepted", acc, 1'b1);
      in_valid = '0;
   endtask

   task automatic idle(input int n);
      in_valid = '0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int sent;
      bit need_new;

      @(negedge clk);
      @(negedge clk);
      #1;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_redir", redir, 0);
      check_val("rst_redir_addr", redir_addr, 0);
      check_val("rst_redir_tag", redir_tag, 0);
      check_val("rst_out_taken", out_taken, 0);
      check_val("rst_out_tag", out_tag, 0);
      check_val("rst_cnt", mispred_cnt, 0);
      check_val("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(negedge clk);

      // Both lanes correctly predicted taken.
      set_lane(0, 1, UO_BEQ, 8'h02, 1, 32'h40, 32'h44, 5'd1);
      set_lane(1, 1, UO_BNE, 8'h00, 1, 32'h80, 32'h84, 5'd2);
      send(4);
      idle(3);

      // Signed less-than mispredict on lane 0 kills lane 1.
      set_lane(0, 1, UO_BLT, 8'h80, 0, 32'h100, 32'h104, 5'd3);
      set_lane(1, 1, UO_BRA, 8'h00, 1, 32'h200, 32'h204, 5'd4);
      send(4);
      idle(3);

      set_lane(0, 1, UO_BHI, 8'h03, 1, 32'h300, 32'h204, 5'd5);
      set_lane(1, 1, UO_BGT, 8'hC0, 1, 32'h400, 32'h404, 5'd6);
      send(4);
      set_lane(0, 1, UO_BGT, 8'hC0, 1, 32'h500, 32'h504, 5'd7);
      set_lane(1, 0, UO_BRN, 8'h00, 0, 32'h0, 32'h0, 5'd8);
      send(4);
      idle(3);

      // Backpressure: three bundles offered while the output is stalled.
      sent = 0;
      need_new = 1'b1;
      for (int c = 0; c < 30 && sent < 3; c++) begin
         out_ready = (c >= 4);
         if (need_new) begin
            rand_bundle();
            in_valid[0] = 1'b1;
         end
         step();
         need_new = acc;
         if (acc) sent++;
      end
      check_val("stall_all_sent", sent, 3);
      out_ready = 1'b1;
      idle(4);

      // Flush with both stages full and a new bundle presented.
      out_ready = 1'b0;
      set_lane(0, 1, UO_BRA, 8'h00, 0, 32'h600, 32'h604, 5'd9);
      set_lane(1, 0, UO_BRA, 8'h00, 0, 32'h0, 32'h0, 5'd0);
      send(2);
      set_lane(0, 1, UO_BRN, 8'h00, 1, 32'h700, 32'h704, 5'd10);
      send(2);
      set_lane(0, 1, UO_BRA, 8'h00, 0, 32'h800, 32'h804, 5'd11);
      flush = 1'b1;
      step();
      flush = 1'b0;
      in_valid = '0;
      out_ready = 1'b1;
      idle(3);
      // Flush on an empty pipeline drops the presented bundle.
      set_lane(0, 1, UO_BRA, 8'h00, 0, 32'h900, 32'h904, 5'd12);
      flush = 1'b1;
      step();
      flush = 1'b0;
      idle(3);

      // Drive the counter into saturation.
      for (int i = 0; i < 18; i++) begin
         set_lane(0, 1, UO_BRA, 8'h00, 0, 32'hA00 + i, 32'hB00, 5'(i));
         set_lane(1, 1, UO_BEQ, 8'h02, 1, 32'hC00, 32'hC04, 5'd31);
         send(3);
      end
      idle(4);
      check_val("cnt_saturated", mispred_cnt, 4'hF);

      // Asynchronous reset while both stages are occupied.
      out_ready = 1'b0;
      set_lane(0, 1, UO_BNE, 8'h02, 1, 32'hD00, 32'hD04, 5'd13);
      set_lane(1, 1, UO_BRA, 8'h00, 1, 32'hE00, 32'hE04, 5'd14);
      send(2);
      set_lane(0, 1, UO_BRA, 8'h00, 0, 32'hF00, 32'hF04, 5'd15);
      send(2);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_out_valid", out_valid, 0);
      check_val("arst_redir", redir, 0);
      check_val("arst_redir_addr", redir_addr, 0);
      check_val("arst_redir_tag", redir_tag, 0);
      check_val("arst_out_taken", out_taken, 0);
      check_val("arst_out_tag", out_tag, 0);
      check_val("arst_cnt", mispred_cnt, 0);
      check_val("arst_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      m_cnt = '0;
      in_valid = '0;
      out_ready = 1'b1;

      for (int c = 0; c < 800; c++) begin
         rand_bundle();
         flush = ($urandom_range(0, 31) == 0);
         out_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
         step();
      end
      flush = 1'b0;
      out_ready = 1'b1;
      idle(5);
      check_val("final_drained", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/gambit_branch_unit.md
# gambit_branch_unit

Parametrised, pipelined branch resolution unit for the Gambit core. It accepts a bundle of up to NCH branch micro-ops per cycle, each with its status-register snapshot and predicted direction. It evaluates the conditions, including signed and unsigned compare conditions the single-op evaluator lacks, and detects mispredictions. It emits one redirect per bundle, for the oldest mispredicting lane, toward fetch/ROB. It sits between the issue stage and the commit/fetch-redirect logic.

## Interface
Parameters:
- NCH, 2, branch lanes per bundle (1..4); lane 0 is oldest
- SRW, 8, status register width (must be ≥ 8)
- AW, 32, address width
- TAGW, 5, ROB tag width
- CNTW, 16, mispredict counter width

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
- flush_i  in  1  kill all in-flight bundles
- in_valid_i  in  NCH  per-lane valid
- in_ready_o  out  1  group ready; bundle accepted when any in_valid_i & in_ready_o
- in_op_i  in  NCH×6  branch micro-op
- in_sr_i  in  NCH×SRW  status snapshot; C=bit0, Z=bit1, V=bit6, N=bit7
- in_pred_i  in  NCH  predicted taken
- in_tgt_i / in_fall_i  in  NCH×AW  taken target / fall-through address
- in_tag_i  in  NCH×TAGW  ROB tag
- out_valid_o  out  NCH  per-lane result valid
- out_ready_i  in  1  downstream accepts bundle
- out_taken_o  out  NCH  resolved direction
- out_tag_o  out  NCH×TAGW  tags
- redir_o  out  1  bundle contains a mispredict
- redir_addr_o  out  AW  correct PC for the oldest mispredicting lane
- redir_tag_o  out  TAGW  tag of that lane
- mispred_cnt_o  out  CNTW  saturating mispredict count

## Operation
- Conditions: BEQ Z; BNE !Z; BCS C; BCC !C; BVS V; BVC !V; BMI N; BPL !N; BHI C&!Z; BLS !C|Z; BGE N==V; BLT N!=V; BGT !Z&(N==V); BLE Z|(N!=V); BRA 1; BRN 0. Undefined opcodes resolve taken (1).
- S1: register the lane fields and the evaluated taken bit.
- S2: mispredict per lane = valid & (taken != pred). Scan from lane 0 upward. The first mispredicting lane k sets redir_o, redir_addr_o = taken ? tgt : fall, and redir_tag_o. Lanes > k have out_valid_o forced 0 (wrong-path kill). Lanes ≤ k keep their own valid.
- mispred_cnt_o increments by 1 per output handshake with redir_o=1. It saturates at all ones.
- flush_i clears S1 and S2 valids at the next edge. A bundle presented in the same cycle as flush_i is dropped. The counter is not affected by flush.

## Timing
- Latency: accept at edge n, results visible after edge n+2 when out_ready_i stays high.
- Full throughput: one bundle per cycle.
- Stall: when out_valid_o≠0 & !out_ready_i, S2 holds. S1 advances only into an empty S2.
- in_ready_o = !S1valid | S1 advancing. It is combinational on out_ready_i and is low during backpressure once S1 is full.
- All outputs are registered or derived from S2 registers. redir_o is qualified by any out_valid_o.
- Reset values: out_valid_o=0, redir_o=0, redir_addr_o=0, redir_tag_o=0, out_taken_o=0, out_tag_o=0, mispred_cnt_o=0, in_ready_o=1.
- Reset asserted mid-operation empties both stages immediately (asynchronous).
- flush_i during a stall drops the held bundle; no handshake occurs.

## Structure
- Shared package gambit_bu_pkg holds:
  - UO_* branch opcode constants, including the new BHI/BLS/BGE/BLT/BGT/BLE/BRN
  - status bit index constants
  - lane struct typedef (op, sr, pred, tgt, fall, tag)
- Sub-module gambit_branch_cond: combinational op+sr → taken, instantiated NCH times.
- Pipeline, arbitration and counter live in the top module.

## Test plan
- Lane0 BEQ sr=0x02 pred=1, lane1 BNE sr=0x00 pred=1 → after 2 cycles, out_valid_o=2'b11, out_taken_o=2'b11, redir_o=0.
- Lane0 BLT sr=0x80 (N=1, V=0) pred=0 tgt=0x100, lane1 valid → redir_o=1, redir_addr_o=0x100, out_valid_o=2'b01, mispred_cnt_o=1 after handshake.
- Lane0 BHI sr=0x03 pred=1 fall=0x204 → taken=0, redir_addr_o=0x204. Lane0 BGT sr=0xC0 → taken=1.
- Hold out_ready_i=0 for 3 cycles with 3 bundles offered → in_ready_o drops after S1 fills; bundles emerge in order with no loss or duplication after release.
- Assert flush_i with both stages full plus a new input → out_valid_o=0 next cycle; accepted input discarded; counter unchanged.
- Preload counter near max (CNTW=4) via 16 mispredicting bundles → mispred_cnt_o=0xF and stays there; async rst_ni low mid-stream → all outputs zero without a clock edge.
